booth_r4_seq_ctrl: RTL

- Sequential radix-4 Booth multiplier controller for signed WIDTH x WIDTH operands.
- Captures an operand pair through a valid/ready handshake.
- Retires one Booth digit per clock. Each digit selects 0, +M, +2M, -M or -2M, shifts it and accumulates it.
- Presents the 2*WIDTH-bit product through a second valid/ready handshake.
- Sits between the operand source and the consumer. Internally it drives the multiplicand negation (two's complement, one bit wider than the operand) and the partial-product selection.

---
 rtl/booth_r4_seq_ctrl_if.sv | 36 +++
 rtl/booth_r4_seq_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/booth_r4_seq_ctrl_if.sv
// Operand/product handshake bundle for the radix-4 Booth multiplier controller.
// The slave modport is the controller; the master modport is the source/consumer side.
interface booth_r4_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                 i_valid;
    logic                 o_ready;
    logic [WIDTH-1:0]     i_multiplicand;
    logic [WIDTH-1:0]     i_multiplier;
    logic                 o_valid;
    logic                 i_ready;
    logic [2*WIDTH-1:0]   o_product;
    logic                 o_busy;

    modport slave (
        input  i_valid,
        input  i_multiplicand,
        input  i_multiplier,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_product,
        output o_busy
    );

    modport master (
        output i_valid,
        output i_multiplicand,
        output i_multiplier,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_product,
        input  o_busy
    );
endinterface

// File: rtl/booth_r4_seq_ctrl.sv
// Sequential radix-4 Booth multiplier: one Booth digit retired per clock, signed
// WIDTH x WIDTH operands in, exact 2*WIDTH-bit product out, valid/ready on both sides.
module booth_r4_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    booth_r4_seq_ctrl_if.slave   bus
);
    localparam int ITER = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;
    localparam int DW   = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  m_q, m_d;
    // Multiplier with the implicit Q[-1]=0 appended; shifted right two bits per digit.
    logic [WIDTH:0]    q_q, q_d;
    logic [PW-1:0]     acc_q, acc_d;

    logic [WIDTH:0]    neg_m;
    logic [WIDTH+1:0]  pp;
    logic [PW-1:0]     pp_ext;
    logic [PW-1:0]     shifted [ITER];

    // Negation one bit wider than M so that -(-2^(WIDTH-1)) stays exact.
    assign neg_m = ~{m_q[WIDTH-1], m_q} + (WIDTH+1)'(1);

    always_comb begin
        pp = '0;
        unique case (q_q[2:0])
            3'b001, 3'b010: pp = {{2{m_q[WIDTH-1]}}, m_q};
            3'b011:         pp = {m_q[WIDTH-1], m_q, 1'b0};
            3'b100:         pp = {neg_m, 1'b0};
            3'b101, 3'b110: pp = {neg_m[WIDTH], neg_m};
            default:        pp = '0;
        endcase
    end

    assign pp_ext = {{(PW-WIDTH-2){pp[WIDTH+1]}}, pp};

    generate
        for (genvar gi = 0; gi < ITER; gi++) begin : g_digit_shift
            assign shifted[gi] = pp_ext << (2 * gi);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    m_d     = bus.i_multiplicand;
                    q_d     = {bus.i_multiplier, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_q + shifted[cnt_q];
                q_d   = q_q >> 2;
                cnt_d = cnt_q + DW'(1);
                if (cnt_q == DW'(ITER - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
        end
    end

    // The accumulator doubles as the product register; it holds through IDLE.
    assign bus.o_ready   = (state_q == S_IDLE);
    assign bus.o_valid   = (state_q == S_DONE);
    assign bus.o_busy    = (state_q == S_RUN);
    assign bus.o_product = acc_q;
endmodule
